// File: rtl/inst_fetch_buffer_if.sv
// ----------------------------------------------------------------------------
// inst_fetch_buffer_if
// Groups the instruction-fetch handshake signals of inst_fetch_buffer.
//   Read-adapter side : pc, pc_re, inst, inst_valid, inst_read_ready
//   Redirect          : flush, flush_pc
//   IF/ID side        : id_ready, out_valid, out_pc, out_inst
// Modports:
//   master - the fetch buffer (drives requests and the FIFO head)
//   slave  - the environment (read adapter, redirect source, IF/ID stage)
// ----------------------------------------------------------------------------
interface inst_fetch_buffer_if;
  logic [31:0] pc;
  logic        pc_re;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_read_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        id_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    output pc, pc_re, inst_read_ready, out_valid, out_pc, out_inst,
    input  inst, inst_valid, flush, flush_pc, id_ready
  );

  modport slave (
    input  pc, pc_re, inst_read_ready, out_valid, out_pc, out_inst,
    output inst, inst_valid, flush, flush_pc, id_ready
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// ----------------------------------------------------------------------------
// inst_fetch_buffer
// Fetch-side consumer of the AXI read adapter's instruction port. Generates
// sequential PCs, issues one request at a time, queues {pc,inst} pairs in a
// small FIFO and presents the FIFO head to IF/ID. A flush redirects fetch,
// empties the FIFO and discards any response still in flight.
//
// Parameters:
//   DEPTH    - FIFO entries (power of two, >= 2)
//   RESET_PC - first fetch address after reset
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - synchronous, active-high reset
//   bus    - inst_fetch_buffer_if.master (adapter, redirect and IF/ID signals)
//   stat_fetch_cnt / stat_drop_cnt / stat_full_cyc (only with
//            FETCH_BUF_STAT_EN defined) - free-running 32-bit statistics
// Optional feature macro: FETCH_BUF_STAT_EN
// ----------------------------------------------------------------------------
module inst_fetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  inst_fetch_buffer_if.master    bus
`ifdef FETCH_BUF_STAT_EN
  ,
  output logic [31:0]            stat_fetch_cnt,
  output logic [31:0]            stat_drop_cnt,
  output logic [31:0]            stat_full_cyc
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,  // nothing outstanding
    ST_WAIT = 2'b01,  // request outstanding, result will be kept
    ST_DROP = 2'b10   // request outstanding, result will be discarded
  } state_t;

  // Redirect targets are word aligned: the two low bits are cleared.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  state_t              state_r;
  logic [31:0]         fetch_pc_r;
  logic [31:0]         req_pc_r;
  logic                pc_re_r;
  logic                read_ready_r;

  logic [31:0]         pc_mem_r   [DEPTH];
  logic [31:0]         inst_mem_r [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                out_valid_r;
  logic [31:0]         out_pc_r;
  logic [31:0]         out_inst_r;

  logic                push_s;
  logic                drop_s;
  logic                pop_s;
  logic                can_issue_s;
  logic [CNT_W-1:0]    cnt_after_pop_s;
  logic [CNT_W-1:0]    count_nxt_s;
  logic [PTR_W-1:0]    rd_ptr_nxt_s;
  logic [PTR_W-1:0]    wr_ptr_nxt_s;
  logic [31:0]         head_pc_nxt_s;
  logic [31:0]         head_inst_nxt_s;

  assign bus.pc              = req_pc_r;
  assign bus.pc_re           = pc_re_r;
  assign bus.inst_read_ready = read_ready_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.out_pc          = out_pc_r;
  assign bus.out_inst        = out_inst_r;

  // FIFO push/pop decisions and next pointer/count/head values.
  always_comb begin
    push_s          = 1'b0;
    drop_s          = 1'b0;
    pop_s           = 1'b0;
    can_issue_s     = 1'b0;
    cnt_after_pop_s = count_r;
    count_nxt_s     = count_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    head_pc_nxt_s   = out_pc_r;
    head_inst_nxt_s = out_inst_r;

    push_s = (state_r == ST_WAIT) && bus.inst_valid && !bus.flush;
    // A response is discarded if flush hits it in WAIT, or it arrives in DROP.
    drop_s = bus.inst_valid &&
             (((state_r == ST_WAIT) && bus.flush) || (state_r == ST_DROP));
    pop_s  = out_valid_r && bus.id_ready && !bus.flush;
    // Issue only when a free slot exists; that slot is implicitly reserved
    // for the response, so a later push can never overflow.
    can_issue_s = (count_r < DEPTH_C);

    if (pop_s) begin
      cnt_after_pop_s = count_r - CNT_ONE;
    end else begin
      cnt_after_pop_s = count_r;
    end

    if (bus.flush) begin
      count_nxt_s  = CNT_ZERO;
      rd_ptr_nxt_s = PTR_ZERO;
      wr_ptr_nxt_s = PTR_ZERO;
    end else begin
      count_nxt_s  = cnt_after_pop_s + (push_s ? CNT_ONE : CNT_ZERO);
      rd_ptr_nxt_s = rd_ptr_r + (pop_s ? PTR_ONE : PTR_ZERO);
      wr_ptr_nxt_s = wr_ptr_r + (push_s ? PTR_ONE : PTR_ZERO);
    end

    // Head registers: when the FIFO drains to empty and receives a push in
    // the same cycle, the new entry is the head; otherwise read the array.
    if (count_nxt_s == CNT_ZERO) begin
      head_pc_nxt_s   = out_pc_r;
      head_inst_nxt_s = out_inst_r;
    end else if (push_s && (cnt_after_pop_s == CNT_ZERO)) begin
      head_pc_nxt_s   = req_pc_r;
      head_inst_nxt_s = bus.inst;
    end else begin
      head_pc_nxt_s   = pc_mem_r[rd_ptr_nxt_s];
      head_inst_nxt_s = inst_mem_r[rd_ptr_nxt_s];
    end
  end

  // Fetch FSM with registered request outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      fetch_pc_r   <= RESET_PC;
      req_pc_r     <= 32'h0000_0000;
      pc_re_r      <= 1'b0;
      read_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.flush) begin
            fetch_pc_r <= word_align(bus.flush_pc);
          end else if (can_issue_s) begin
            req_pc_r     <= fetch_pc_r;
            state_r      <= ST_WAIT;
            pc_re_r      <= 1'b1;
            read_ready_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (bus.flush) begin
            fetch_pc_r <= word_align(bus.flush_pc);
            if (bus.inst_valid) begin
              state_r      <= ST_IDLE;
              pc_re_r      <= 1'b0;
              read_ready_r <= 1'b0;
            end else begin
              state_r <= ST_DROP;
            end
          end else if (bus.inst_valid) begin
            fetch_pc_r   <= req_pc_r + 32'd4;
            state_r      <= ST_IDLE;
            pc_re_r      <= 1'b0;
            read_ready_r <= 1'b0;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_DROP: begin
          if (bus.flush) begin
            fetch_pc_r <= word_align(bus.flush_pc);
          end
          if (bus.inst_valid) begin
            state_r      <= ST_IDLE;
            pc_re_r      <= 1'b0;
            read_ready_r <= 1'b0;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          pc_re_r      <= 1'b0;
          read_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage, pointers, occupancy and registered head outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r    <= PTR_ZERO;
      wr_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      out_valid_r <= 1'b0;
      out_pc_r    <= 32'h0000_0000;
      out_inst_r  <= 32'h0000_0000;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]   <= req_pc_r;
        inst_mem_r[wr_ptr_r] <= bus.inst;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != CNT_ZERO);
      out_pc_r    <= head_pc_nxt_s;
      out_inst_r  <= head_inst_nxt_s;
    end
  end

`ifdef FETCH_BUF_STAT_EN
  logic [31:0] stat_fetch_r;
  logic [31:0] stat_drop_r;
  logic [31:0] stat_full_r;

  assign stat_fetch_cnt = stat_fetch_r;
  assign stat_drop_cnt  = stat_drop_r;
  assign stat_full_cyc  = stat_full_r;

  // Statistics counters; free-running, untouched by flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetch_r <= 32'h0000_0000;
      stat_drop_r  <= 32'h0000_0000;
      stat_full_r  <= 32'h0000_0000;
    end else begin
      if (push_s) begin
        stat_fetch_r <= stat_fetch_r + 32'd1;
      end
      if (drop_s) begin
        stat_drop_r <= stat_drop_r + 32'd1;
      end
      if ((state_r == ST_IDLE) && (count_r == DEPTH_C)) begin
        stat_full_r <= stat_full_r + 32'd1;
      end
    end
  end
`else
  // Without statistics the discard indication has no consumer.
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_buffer
// Self-checking bench: a transaction-level model (outstanding flag, discard
// flag, fetch/request PCs and a queue of {pc,inst}) predicts every output
// after each clock; directed sequences pin literal values, then a randomized
// phase exercises flush, reset, back-pressure and variable response latency.
// ----------------------------------------------------------------------------
module tb_inst_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_fetch_buffer_if bus ();

`ifdef FETCH_BUF_STAT_EN
  logic [31:0] stat_fetch_cnt, stat_drop_cnt, stat_full_cyc;
  int unsigned m_fetch, m_drop, m_full;
`endif

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_BUF_STAT_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_drop_cnt  (stat_drop_cnt),
    .stat_full_cyc  (stat_full_cyc)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit          m_busy;
  bit          m_discard;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  logic [63:0] mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit pop, resp, keep, issue;
    logic [31:0] old_fetch;
    if (reset) begin
      m_busy = 1'b0; m_discard = 1'b0;
      m_fetch_pc = RESET_PC; m_req_pc = 32'h0;
      mq.delete();
`ifdef FETCH_BUF_STAT_EN
      m_fetch = 0; m_drop = 0; m_full = 0;
`endif
    end else begin
      pop   = (mq.size() > 0) && bus.id_ready && !bus.flush;
      resp  = m_busy && bus.inst_valid;
      keep  = resp && !m_discard && !bus.flush;
      issue = !m_busy && !bus.flush && (mq.size() < DEPTH);
`ifdef FETCH_BUF_STAT_EN
      if (keep) m_fetch++;
      if (resp && !keep) m_drop++;
      if (!m_busy && mq.size() == DEPTH) m_full++;
`endif
      old_fetch = m_fetch_pc;
      if (pop) void'(mq.pop_front());
      if (keep) begin
        mq.push_back({m_req_pc, bus.inst});
        m_fetch_pc = m_req_pc + 32'd4;
      end
      if (bus.flush) begin
        mq.delete();
        m_fetch_pc = bus.flush_pc & 32'hFFFF_FFFC;
      end
      if (resp) begin
        m_busy = 1'b0; m_discard = 1'b0;
      end else if (m_busy && bus.flush) begin
        m_discard = 1'b1;
      end
      if (issue) begin
        m_busy = 1'b1; m_req_pc = old_fetch;
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    logic [63:0] head;
    chk("pc_re", {31'd0, bus.pc_re}, {31'd0, m_busy});
    chk("inst_read_ready", {31'd0, bus.inst_read_ready}, {31'd0, m_busy});
    chk("pc", bus.pc, m_req_pc);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (mq.size() > 0)});
    if (mq.size() > 0) begin
      head = mq[0];
      chk("out_pc", bus.out_pc, head[63:32]);
      chk("out_inst", bus.out_inst, head[31:0]);
    end
`ifdef FETCH_BUF_STAT_EN
    chk("stat_fetch", stat_fetch_cnt, m_fetch);
    chk("stat_drop", stat_drop_cnt, m_drop);
    chk("stat_full", stat_full_cyc, m_full);
`endif
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_in(input bit fl, input logic [31:0] fpc, input bit iv,
                        input logic [31:0] ins, input bit rdy);
    bus.flush = fl; bus.flush_pc = fpc; bus.inst_valid = iv;
    bus.inst = ins; bus.id_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(); step();
    reset = 1'b0;
  endtask

  // Bounded wait for an outstanding request (no responses given meanwhile).
  task automatic wait_busy();
    for (int i = 0; i < 20 && !m_busy; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      step();
    end
    if (!m_busy) begin
      checks++; failures++;
      $display("FAIL wait_busy actual=idle required=outstanding at %0t", $time);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);

    // Reset state.
    do_reset();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_pc_re", {31'd0, bus.pc_re}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0);

    // Sequential fetch with 1-cycle response latency.
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    chk("seq_pc0", bus.pc, 32'hBFC0_0000);
    set_in(1'b0, 32'h0, 1'b1, 32'h1111_0000, 1'b1); step();
    chk("seq_head_pc", bus.out_pc, 32'hBFC0_0000);
    chk("seq_head_inst", bus.out_inst, 32'h1111_0000);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    chk("seq_pc1", bus.pc, 32'hBFC0_0004);
    chk("seq_pc_re1", {31'd0, bus.pc_re}, 32'd1);

    // Fill with IF/ID stalled: exactly DEPTH pushes, then no request.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_in(1'b0, 32'h0, m_busy, 32'hA000_0000 + i, 1'b0); step();
    end
    chk("full_pc_re", {31'd0, bus.pc_re}, 32'd0);
    chk("full_last_pc", bus.pc, 32'hBFC0_000C);
    chk("full_head_pc", bus.out_pc, 32'hBFC0_0000);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    chk("resume_head_pc", bus.out_pc, 32'hBFC0_0004);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 32'h0, m_busy, $urandom, 1'b1); step();
    end

    // Flush while waiting; response arrives 3 cycles later and is dropped.
    wait_busy();
    set_in(1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b1); step();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    chk("drop_pc_re_held", {31'd0, bus.pc_re}, 32'd1);
    set_in(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1); step();
    chk("drop_out_valid", {31'd0, bus.out_valid}, 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    chk("redirect_pc", bus.pc, 32'h8000_0100);
    set_in(1'b0, 32'h0, 1'b1, 32'h5555_AAAA, 1'b1); step();
    chk("redirect_head_pc", bus.out_pc, 32'h8000_0100);
    chk("redirect_head_inst", bus.out_inst, 32'h5555_AAAA);

    // Flush and response in the same cycle.
    wait_busy();
    set_in(1'b1, 32'h8000_0200, 1'b1, 32'h1234_5678, 1'b1); step();
    chk("flush_iv_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_iv_pc_re", {31'd0, bus.pc_re}, 32'd0);
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    chk("flush_iv_pc", bus.pc, 32'h8000_0200);

    // Unaligned redirect target.
    set_in(1'b1, 32'h8000_0103, m_busy, 32'h0, 1'b1); step();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    chk("align_pc", bus.pc, 32'h8000_0100);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      set_in(($urandom_range(0, 24) == 0), $urandom,
             m_busy && ($urandom_range(0, 2) == 0), $urandom,
             ($urandom_range(0, 1) == 1));
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
